multi_ff_sync: RTL
==================

// Module: multi_ff_sync
// PURPOSE
//   Parametrised multi-bit, N-stage synchroniser for asynchronous level inputs into the clk domain.
//   Each channel gets a synchronised level plus single-cycle rise/fall pulses.
//   Intended for switches, status lines and interrupt requests entering the core.
//   Not for multi-bit buses needing coherence; each bit is synchronised independently.
// PARAMETERS
//   WIDTH         4     number of independent channels (>=1)
//   STAGES        2     synchroniser flop depth (>=2; elaboration $error if less)
//   RST_VAL       '0    [WIDTH-1:0] reset value of every stage, dout and edge history
//   FILTER_CYCLES 4     debounce length in clk cycles (>=1), used only with SYNC_FILTER_EN
// PORTS
//   clk      in   1      destination clock
//   rst_n    in   1      reset rst_n, asynchronous, active-low; clock clk
//   din      in   WIDTH  asynchronous level inputs
//   dout     out  WIDTH  synchronised (optionally debounced) levels
//   rise     out  WIDTH  1-cycle pulse per channel when dout goes 0->1
//   fall     out  WIDTH  1-cycle pulse per channel when dout goes 1->0
//   changed  out  1      OR of (rise | fall) across all channels
// BEHAVIOUR
//   - Reset (async assert, sync-by-design release): all sync stages, filter state, dout and
//     edge-history register = RST_VAL; rise = fall = 0, changed = 0. No pulse on reset release.
//   - Sync chain: stage[0] <= din; stage[i] <= stage[i-1]; s = stage[STAGES-1].
//   - Latency (no filter): din stable before edge k -> dout updated after edge k+STAGES-1.
//   - Edge detect: prev <= dout each cycle; rise = dout & ~prev; fall = ~dout & prev.
//     Outputs derive only from flops; din never has a combinational path to any output.
//   - rise and fall are mutually exclusive per channel; exactly one cycle wide.
//   - Channels fully independent; simultaneous edges on several channels all pulse same cycle.
//   - Reset mid-operation: pulses drop immediately; after release outputs resume from RST_VAL,
//     first pulse only if s differs from RST_VAL after STAGES cycles.
// CONFIGURATION
//   `SYNC_FILTER_EN defined: per-channel debounce between s and dout.
//     - cnt width $clog2(FILTER_CYCLES+1), reset 0.
//     - s != dout: cnt++; when cnt reaches FILTER_CYCLES-1 and still differs, dout <= s, cnt <= 0.
//     - s == dout at any cycle: cnt <= 0 (glitch discarded).
//     - Latency = STAGES + FILTER_CYCLES - 1 edges; pulses shorter than FILTER_CYCLES never seen.
//   `SYNC_FILTER_EN undefined: dout = s; no counters instantiated; FILTER_CYCLES ignored.
// STRUCTURE
//   - sync_pkg: function cnt_w(int n) = $clog2(n+1); localparam MIN_STAGES = 2.
//   - Sub-module sync_filter_ch (1-bit debounce: clk, rst_n, s_in, rst_val, lvl_out),
//     generate-instantiated WIDTH times under `SYNC_FILTER_EN.
//   - Sync stages held in logic [STAGES-1:0][WIDTH-1:0]; tool attribute marks them async_reg.
// TESTING
//   1. WIDTH=4,STAGES=2,RST_VAL=0: din 0->4'h5 at t0 -> dout=4'h5 after 2 edges; rise=4'h5 1 cycle, changed=1.
//   2. STAGES=3: din 4'hF->0 -> dout=0 exactly 3 edges later; fall=4'hF for 1 cycle, rise=0.
//   3. RST_VAL=4'hA, din=4'hA across reset release -> no rise/fall/changed pulses ever.
//   4. FILTER on, FILTER_CYCLES=4: bit0 high for 3 cycles -> dout unchanged, no pulse;
//      high for 4 cycles -> dout[0]=1 at STAGES+3 edges after din, rise[0] pulse.
//   5. Assert rst_n low while rise[1]=1 -> rise=0 immediately, dout=RST_VAL same time.
//   6. Random async din (jittered edges) vs. reference model: dout equals din delayed, pulses 1-wide.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-bit level synchroniser.
//   MIN_STAGES : shallowest legal synchroniser chain
//   cnt_w(n)   : bits needed to hold values 0..n
package sync_pkg;

    localparam int unsigned MIN_STAGES = 2;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// Single-channel debounce behind a synchroniser chain.
// lvl_out follows s_in only once s_in has disagreed with it on FILTER_CYCLES
// consecutive clk samples; any agreeing sample discards the partial count.
// Ports:
//   clk      in  1  destination clock
//   rst_n    in  1  asynchronous active-low reset
//   s_in     in  1  synchronised (metastability-free) level
//   rst_val  in  1  level loaded into lvl_out during reset
//   lvl_out  out 1  debounced level (registered)
module sync_filter_ch
    import sync_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_in,
    input  logic rst_val,
    output logic lvl_out
);

    localparam int unsigned   CW       = cnt_w(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count consecutive disagreeing samples; commit the new level on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            lvl_out <= rst_val;
        end else if (s_in != lvl_out) begin
            if (cnt == CNT_LAST) begin
                lvl_out <= s_in;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/multi_ff_sync.sv
// Parametrised N-stage synchroniser for WIDTH independent asynchronous level
// inputs, with per-channel rise/fall pulses and a global change flag.
// Bits are synchronised independently: not for coherent multi-bit buses.
// Optional debounce between the chain and dout: define SYNC_FILTER_EN.
// Ports:
//   clk      in  1      destination clock
//   rst_n    in  1      asynchronous active-low reset
//   din      in  WIDTH  asynchronous level inputs
//   dout     out WIDTH  synchronised (optionally debounced) levels, registered
//   rise     out WIDTH  1-cycle pulse when dout goes 0->1 (decoded from flops only)
//   fall     out WIDTH  1-cycle pulse when dout goes 1->0 (decoded from flops only)
//   changed  out 1      OR of rise|fall across all channels
module multi_ff_sync
    import sync_pkg::*;
#(
    parameter int unsigned       WIDTH         = 4,
    parameter int unsigned       STAGES        = 2,
    parameter logic [WIDTH-1:0]  RST_VAL       = '0,
    parameter int unsigned       FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Elaboration-time parameter sanity.
    if (STAGES < MIN_STAGES) begin : g_bad_stages
        $error("multi_ff_sync: STAGES must be >= %0d", MIN_STAGES);
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("multi_ff_sync: FILTER_CYCLES must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("multi_ff_sync: WIDTH must be >= 1");
    end

    (* async_reg = "true" *) logic [STAGES-1:0][WIDTH-1:0] stage;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] prev;

    // Synchroniser chain: stage[0] captures din, the last stage is metastability-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= {STAGES{RST_VAL}};
        end else begin
            stage <= {stage[STAGES-2:0], din};
        end
    end

    assign s = stage[STAGES-1];

`ifdef SYNC_FILTER_EN
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_filter
        sync_filter_ch #(
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_filter (
            .clk     (clk),
            .rst_n   (rst_n),
            .s_in    (s[i]),
            .rst_val (RST_VAL[i]),
            .lvl_out (dout[i])
        );
    end
`else
    assign dout = s;
`endif

    // Edge history; reset to RST_VAL so release never produces a pulse by itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= RST_VAL;
        end else begin
            prev <= dout;
        end
    end

    assign rise    = dout & ~prev;
    assign fall    = ~dout & prev;
    assign changed = |(rise | fall);

endmodule
